// File: rtl/rf_pkg.sv
// Shared definitions for the register file with pending-write scoreboard.
package rf_pkg;

    localparam int RF_WIDTH     = 16;
    localparam int RF_ADDR_BITS = 3;

    // Reserved for a future status register that reports why err fired.
    typedef enum logic {
        ERR_WAW    = 1'b0,
        ERR_ORPHAN = 1'b1
    } err_cause_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, issue wins a tie.
// err pulses one cycle after a WAW issue or an orphan writeback.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_BITS = RF_ADDR_BITS,
    parameter bit ZERO_REG  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue,
    input  logic [ADDR_BITS-1:0]          issueregsel,
    input  logic                          write,
    input  logic [ADDR_BITS-1:0]          writeregsel,
    output logic [(1 << ADDR_BITS)-1:0]   busy_vec,
    output logic                          err
);

    localparam int NREGS = 1 << ADDR_BITS;

    logic [NREGS-1:0] busy_q, busy_d;
    logic             err_q, err_d;

    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        err_d  = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            logic iss_hit;
            logic wr_hit;
            iss_hit = issue && (issueregsel == ADDR_BITS'(r)) && !(ZERO_REG && r == 0);
            wr_hit  = write && (writeregsel == ADDR_BITS'(r)) && !(ZERO_REG && r == 0);
            busy_d[r] = iss_hit || (busy_q[r] && !wr_hit);
            // WAW: re-issue while still pending; orphan: writeback nobody is waiting for.
            if ((iss_hit && busy_q[r] && !wr_hit) || (wr_hit && !busy_q[r] && !iss_hit)) begin
                err_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_vec = busy_q;
    assign err      = err_q;

endmodule

// File: rtl/rf_sb.sv
// Two-read/one-write register file with optional write bypass, optional
// hardwired-zero r0, and a pending-write scoreboard for decode/issue.
module rf_sb
    import rf_pkg::*;
#(
    parameter int WIDTH     = RF_WIDTH,
    parameter int ADDR_BITS = RF_ADDR_BITS,
    parameter bit BYPASS    = 1'b1,
    parameter bit ZERO_REG  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] read1regsel,
    input  logic [ADDR_BITS-1:0] read2regsel,
    output logic [WIDTH-1:0]     read1data,
    output logic [WIDTH-1:0]     read2data,
    output logic                 busy1,
    output logic                 busy2,
    input  logic                 write,
    input  logic [ADDR_BITS-1:0] writeregsel,
    input  logic [WIDTH-1:0]     writedata,
    input  logic                 issue,
    input  logic [ADDR_BITS-1:0] issueregsel,
    output logic                 err
);

    localparam int NREGS = 1 << ADDR_BITS;

    logic [WIDTH-1:0]     mem_q [NREGS];
    logic [WIDTH-1:0]     mem_d [NREGS];
    logic [NREGS-1:0]     busy_vec;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] rsel  [2];
    logic [WIDTH-1:0]     rdata [2];
    logic                 rbusy [2];

    rf_scoreboard #(
        .ADDR_BITS (ADDR_BITS),
        .ZERO_REG  (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue),
        .issueregsel (issueregsel),
        .write       (write),
        .writeregsel (writeregsel),
        .busy_vec    (busy_vec),
        .err         (err)
    );

    assign wr_en = write && !(ZERO_REG && writeregsel == '0);

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[writeregsel] = writedata;
        end
    end

    // NOTE: the storage array is reset because software expects every register to read 0 after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rsel[0] = read1regsel;
    assign rsel[1] = read2regsel;

    // A same-cycle writeback both forwards its data and hides the busy flag it is about to clear.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = mem_q[rsel[p]];
            rbusy[p] = busy_vec[rsel[p]];
            if (BYPASS && write && (writeregsel == rsel[p])) begin
                if (wr_en) begin
                    rdata[p] = writedata;
                end
                rbusy[p] = 1'b0;
            end
            if (ZERO_REG && rsel[p] == '0) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign read1data = rdata[0];
    assign read2data = rdata[1];
    assign busy1     = rbusy[0];
    assign busy2     = rbusy[1];

endmodule

// File: tb/tb_rf_sb.sv
// Bench for rf_sb: table-driven main sequence on a bypassing instance, plus
// hand sequences for reset-in-flight, BYPASS=0 and ZERO_REG=1 instances.
module tb_rf_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  read1regsel, read2regsel, writeregsel, issueregsel;
    logic        write, issue;
    logic [15:0] writedata;

    logic [15:0] b_rd1, b_rd2, n_rd1, n_rd2, z_rd1, z_rd2;
    logic        b_bz1, b_bz2, n_bz1, n_bz2, z_bz1, z_bz2;
    logic        b_err, n_err, z_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_sb #(.WIDTH(16), .ADDR_BITS(3), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_byp (
        .clk(clk), .rst(rst), .read1regsel(read1regsel), .read2regsel(read2regsel),
        .read1data(b_rd1), .read2data(b_rd2), .busy1(b_bz1), .busy2(b_bz2),
        .write(write), .writeregsel(writeregsel), .writedata(writedata),
        .issue(issue), .issueregsel(issueregsel), .err(b_err)
    );

    rf_sb #(.WIDTH(16), .ADDR_BITS(3), .BYPASS(1'b0), .ZERO_REG(1'b0)) u_nobyp (
        .clk(clk), .rst(rst), .read1regsel(read1regsel), .read2regsel(read2regsel),
        .read1data(n_rd1), .read2data(n_rd2), .busy1(n_bz1), .busy2(n_bz2),
        .write(write), .writeregsel(writeregsel), .writedata(writedata),
        .issue(issue), .issueregsel(issueregsel), .err(n_err)
    );

    rf_sb #(.WIDTH(16), .ADDR_BITS(3), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_zero (
        .clk(clk), .rst(rst), .read1regsel(read1regsel), .read2regsel(read2regsel),
        .read1data(z_rd1), .read2data(z_rd2), .busy1(z_bz1), .busy2(z_bz2),
        .write(write), .writeregsel(writeregsel), .writedata(writedata),
        .issue(issue), .issueregsel(issueregsel), .err(z_err)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  wsel;
        logic [15:0] wdata;
        logic        iss;
        logic [2:0]  isel;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        eb1;
        logic        eb2;
        logic        eerr;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl [NVEC];
    logic err_q [$];

    function automatic vec_t mk(logic wr, logic [2:0] wsel, logic [15:0] wdata,
                                logic iss, logic [2:0] isel, logic [2:0] s1, logic [2:0] s2,
                                logic [15:0] e1, logic [15:0] e2, logic eb1, logic eb2, logic eerr);
        vec_t v;
        v.wr = wr; v.wsel = wsel; v.wdata = wdata; v.iss = iss; v.isel = isel;
        v.s1 = s1; v.s2 = s2; v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2; v.eerr = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [2:0] wsel, input logic [15:0] wdata,
                         input logic iss, input logic [2:0] isel,
                         input logic [2:0] s1, input logic [2:0] s2);
        write = wr; writeregsel = wsel; writedata = wdata;
        issue = iss; issueregsel = isel;
        read1regsel = s1; read2regsel = s2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // wr wsel wdata  iss isel  s1 s2  e1       e2       b1 b2 err_next
        tbl[0]  = mk(1, 5, 16'hBEEF, 0, 0, 5, 5, 16'hBEEF, 16'hBEEF, 0, 0, 1); // orphan, bypass both ports
        tbl[1]  = mk(0, 0, 16'h0,    0, 0, 5, 5, 16'hBEEF, 16'hBEEF, 0, 0, 0);
        tbl[2]  = mk(1, 3, 16'h1234, 0, 0, 3, 5, 16'h1234, 16'hBEEF, 0, 0, 1);
        tbl[3]  = mk(0, 0, 16'h0,    1, 2, 2, 3, 16'h0000, 16'h1234, 0, 0, 0); // issue r2
        tbl[4]  = mk(0, 0, 16'h0,    0, 0, 2, 2, 16'h0000, 16'h0000, 1, 1, 0);
        tbl[5]  = mk(0, 0, 16'h0,    0, 0, 2, 3, 16'h0000, 16'h1234, 1, 0, 0);
        tbl[6]  = mk(1, 2, 16'h5555, 0, 0, 2, 2, 16'h5555, 16'h5555, 0, 0, 0); // writeback masks busy
        tbl[7]  = mk(0, 0, 16'h0,    0, 0, 2, 2, 16'h5555, 16'h5555, 0, 0, 0);
        tbl[8]  = mk(0, 0, 16'h0,    1, 4, 4, 0, 16'h0000, 16'h0000, 0, 0, 0);
        tbl[9]  = mk(1, 4, 16'h00AA, 1, 4, 4, 4, 16'h00AA, 16'h00AA, 0, 0, 0); // issue+write same reg
        tbl[10] = mk(0, 0, 16'h0,    0, 0, 4, 4, 16'h00AA, 16'h00AA, 1, 1, 0);
        tbl[11] = mk(1, 4, 16'h00BB, 0, 0, 4, 0, 16'h00BB, 16'h0000, 0, 0, 0);
        tbl[12] = mk(0, 0, 16'h0,    1, 1, 1, 4, 16'h0000, 16'h00BB, 0, 0, 0);
        tbl[13] = mk(0, 0, 16'h0,    1, 1, 1, 4, 16'h0000, 16'h00BB, 1, 0, 1); // WAW
        tbl[14] = mk(0, 0, 16'h0,    0, 0, 1, 4, 16'h0000, 16'h00BB, 1, 0, 0);
        tbl[15] = mk(0, 0, 16'h0,    0, 0, 1, 1, 16'h0000, 16'h0000, 1, 1, 0);
        tbl[16] = mk(1, 6, 16'h6666, 1, 1, 6, 1, 16'h6666, 16'h0000, 0, 1, 1); // orphan+WAW, one pulse
        tbl[17] = mk(0, 0, 16'h0,    0, 0, 6, 1, 16'h6666, 16'h0000, 0, 1, 0);
        tbl[18] = mk(1, 1, 16'h1111, 0, 0, 1, 6, 16'h1111, 16'h6666, 0, 0, 0);
        tbl[19] = mk(0, 0, 16'h0,    0, 0, 1, 6, 16'h1111, 16'h6666, 0, 0, 0);

        do_reset();
        #1;
        check("reset rd1", b_rd1, 16'h0);
        check("reset rd2", b_rd2, 16'h0);
        check("reset err", b_err, 1'b0);
        check("reset busy1", b_bz1, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            if (err_q.size() > 0) check($sformatf("s%0d prev err", i), b_err, err_q.pop_front());
            drive(tbl[i].wr, tbl[i].wsel, tbl[i].wdata, tbl[i].iss, tbl[i].isel, tbl[i].s1, tbl[i].s2);
            #1;
            check($sformatf("s%0d rd1", i), b_rd1, tbl[i].e1);
            check($sformatf("s%0d rd2", i), b_rd2, tbl[i].e2);
            check($sformatf("s%0d busy1", i), b_bz1, tbl[i].eb1);
            check($sformatf("s%0d busy2", i), b_bz2, tbl[i].eb2);
            err_q.push_back(tbl[i].eerr);
        end
        @(negedge clk);
        while (err_q.size() > 0) check("tail err", b_err, err_q.pop_front());

        // Reset with a pending issue plus a WAW issue and a writeback in the reset cycle.
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 3'd7, 3'd5);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd7, 3'd5);
        #1;
        check("pre-rst busy r7", b_bz1, 1'b1);
        rst = 1'b1;
        drive(1'b1, 3'd5, 16'h7777, 1'b1, 3'd7, 3'd7, 3'd5);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd7, 3'd5);
        #1;
        check("rst-mid err", b_err, 1'b0);
        check("rst-mid busy r7", b_bz1, 1'b0);
        check("rst-mid r7", b_rd1, 16'h0);
        check("rst-mid r5", b_rd2, 16'h0);
        @(negedge clk);
        #1;
        check("rst-mid err later", b_err, 1'b0);

        // BYPASS=0: old data during the write cycle, busy not masked.
        @(negedge clk);
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd3, 3'd3);
        #1;
        check("nobyp rd1 same cycle", n_rd1, 16'h0);
        check("byp rd1 same cycle", b_rd1, 16'h1234);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd3);
        #1;
        check("nobyp rd1 next cycle", n_rd1, 16'h1234);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd2, 3'd2);
        @(negedge clk);
        drive(1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 3'd2, 3'd2);
        #1;
        check("nobyp busy unmasked", n_bz1, 1'b1);
        check("byp busy masked", b_bz1, 1'b0);
        check("nobyp rd1 old", n_rd1, 16'h0);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd2, 3'd2);
        #1;
        check("nobyp busy cleared", n_bz1, 1'b0);
        check("nobyp rd1 written", n_rd1, 16'h2222);
        check("nobyp err", n_err, 1'b0);

        // ZERO_REG=1: r0 ignores writes and issues and never errs.
        do_reset();
        drive(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0, 3'd0);
        #1;
        check("zero rd1 write cycle", z_rd1, 16'h0);
        check("zero rd2 write cycle", z_rd2, 16'h0);
        check("plain rd1 bypass r0", b_rd1, 16'hFFFF);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0, 3'd0);
        #1;
        check("zero err orphan r0", z_err, 1'b0);
        check("plain err orphan r0", b_err, 1'b1);
        check("zero rd1 after write", z_rd1, 16'h0);
        check("plain rd1 after write", b_rd1, 16'hFFFF);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0, 3'd0);
        #1;
        check("zero busy r0", z_bz1, 1'b0);
        check("plain busy r0", b_bz1, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        #1;
        check("zero err waw r0", z_err, 1'b0);
        check("plain err waw r0", b_err, 1'b1);
        check("zero busy r0 later", z_bz1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
